// File: rtl/boot_pkg.sv
// Shared types and defaults for the boot loader: state encoding, parameter defaults
// and the width of the word counter that ends the copy.
package boot_pkg;

    localparam int DEF_ADDR_WIDTH    = 8;
    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_LENGTH        = 256;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_COUNT_WIDTH   = DEF_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        COPY   = 2'd1,
        FLUSH  = 2'd2,
        RUN    = 2'd3
    } boot_state_e;

    // One extra bit so a full 2**ADDR_WIDTH image can be counted without wrapping.
    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/boot_settle_counter.sv
// Free-running up-counter with a terminal-count flag, async active-low clear and
// synchronous restart; usable for any startup settle delay.
module boot_settle_counter #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = restart ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == WIDTH'(TERMINAL - 1));

endmodule

// File: rtl/boot_loader.sv
// Copies a fixed-length image from a registered-read ROM into RAM after reset or a
// reload request, holding the CPU in reset until the last word has been written.
module boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int LENGTH        = DEF_LENGTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reload,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = count_width(ADDR_WIDTH);

    boot_state_e           state_q,     state_d;
    logic [CW-1:0]         cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q,  rom_addr_d;
    logic                  data_vld_q,  data_vld_d;
    logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
    logic                  ram_we_q,    ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  settle_tc;
    logic                  settle_restart;

    assign settle_restart = (state_q != SETTLE) || settle_tc;

    boot_settle_counter #(
        .WIDTH    (8),
        .TERMINAL (SETTLE_CYCLES)
    ) u_settle (
        .clk     (clk),
        .rst_n   (reset),
        .restart (settle_restart),
        .tc      (settle_tc)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        case (state_q)
            SETTLE: begin
                if (settle_tc) begin
                    state_d    = COPY;
                    rom_addr_d = '0;
                    cnt_d      = CW'(1);
                end
            end
            COPY: begin
                // cnt_q counts reads already issued, so it doubles as the next address.
                if (cnt_q == CW'(LENGTH)) begin
                    state_d = FLUSH;
                end else begin
                    rom_addr_d = cnt_q[ADDR_WIDTH-1:0];
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (ram_we_q && !data_vld_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (reload) begin
                    state_d    = SETTLE;
                    cnt_d      = '0;
                    rom_addr_d = '0;
                end
            end
            default: state_d = SETTLE;
        endcase

        // ROM data for the address on rom_addr_q arrives one cycle later.
        data_vld_d  = (state_q == COPY);
        data_addr_d = rom_addr_q;
        ram_we_d    = data_vld_q;
        ram_addr_d  = data_vld_q ? data_addr_q : ram_addr_q;
        ram_wdata_d = data_vld_q ? rom_data    : ram_wdata_q;

        cpu_reset_d = (state_d != RUN);
        busy_d      = (state_d != RUN);
        done_d      = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SETTLE;
            cnt_q       <= '0;
            rom_addr_q  <= '0;
            data_vld_q  <= 1'b0;
            data_addr_q <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rom_addr_q  <= rom_addr_d;
            data_vld_q  <= data_vld_d;
            data_addr_q <= data_addr_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a 4-word image driven from a cycle table, plus a
// full 256-word wrap instance and a 1-word / 1-settle instance.
module tb_boot_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: LENGTH=4, SETTLE_CYCLES=4, ROM[i] = 0xA0 + i
    logic       reset_a = 1'b0, reload_a = 1'b0;
    logic [7:0] rom_a_addr, rom_a_data = 8'h00, ram_a_addr, ram_a_wdata;
    logic       ram_a_we, cpu_a_reset, busy_a, done_a;

    boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LENGTH(4), .SETTLE_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset_a), .reload(reload_a),
        .rom_addr(rom_a_addr), .rom_data(rom_a_data),
        .ram_we(ram_a_we), .ram_addr(ram_a_addr), .ram_wdata(ram_a_wdata),
        .cpu_reset(cpu_a_reset), .busy(busy_a), .done(done_a)
    );
    always_ff @(posedge clk) rom_a_data <= 8'hA0 + rom_a_addr;

    // Instance B: LENGTH=256, ROM[i] = i ^ 0x5A
    logic       reset_b = 1'b0, reload_b = 1'b0;
    logic [7:0] rom_b_addr, rom_b_data = 8'h00, ram_b_addr, ram_b_wdata;
    logic       ram_b_we, cpu_b_reset, busy_b, done_b;

    boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LENGTH(256), .SETTLE_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset_b), .reload(reload_b),
        .rom_addr(rom_b_addr), .rom_data(rom_b_data),
        .ram_we(ram_b_we), .ram_addr(ram_b_addr), .ram_wdata(ram_b_wdata),
        .cpu_reset(cpu_b_reset), .busy(busy_b), .done(done_b)
    );
    always_ff @(posedge clk) rom_b_data <= rom_b_addr ^ 8'h5A;

    // Instance C: LENGTH=1, SETTLE_CYCLES=1, ROM[i] = 0x3C ^ i
    logic       reset_c = 1'b0, reload_c = 1'b0;
    logic [7:0] rom_c_addr, rom_c_data = 8'h00, ram_c_addr, ram_c_wdata;
    logic       ram_c_we, cpu_c_reset, busy_c, done_c;

    boot_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LENGTH(1), .SETTLE_CYCLES(1)) dut_c (
        .clk(clk), .reset(reset_c), .reload(reload_c),
        .rom_addr(rom_c_addr), .rom_data(rom_c_data),
        .ram_we(ram_c_we), .ram_addr(ram_c_addr), .ram_wdata(ram_c_wdata),
        .cpu_reset(cpu_c_reset), .busy(busy_c), .done(done_c)
    );
    always_ff @(posedge clk) rom_c_data <= rom_c_addr ^ 8'h3C;

    typedef struct {
        logic       chk_rom;
        logic [7:0] rom_addr;
        logic       we;
        logic [7:0] waddr;
        logic [7:0] wdata;
        logic       cpu_reset;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl [1:11];

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d actual=0x%0h required=0x%0h", name, row, act, exp);
        end
    endtask

    // Row n is sampled after the n-th rising edge following release (or reload edge).
    // reload_after_row>0 pulses reload during the cycle after that row.
    task automatic run_table(input string tag, input int reload_after_row);
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk);
            @(negedge clk);
            reload_a = 1'b0;
            if (tbl[n].chk_rom) chk({tag, ".rom_addr"}, n, 32'(rom_a_addr), 32'(tbl[n].rom_addr));
            chk({tag, ".ram_we"}, n, 32'(ram_a_we), 32'(tbl[n].we));
            if (tbl[n].we) begin
                chk({tag, ".ram_addr"}, n, 32'(ram_a_addr), 32'(tbl[n].waddr));
                chk({tag, ".ram_wdata"}, n, 32'(ram_a_wdata), 32'(tbl[n].wdata));
            end
            chk({tag, ".cpu_reset"}, n, 32'(cpu_a_reset), 32'(tbl[n].cpu_reset));
            chk({tag, ".busy"}, n, 32'(busy_a), 32'(tbl[n].busy));
            chk({tag, ".done"}, n, 32'(done_a), 32'(tbl[n].done));
            $display("%s row %0d: rom_addr=%0d we=%0b addr=%0d wdata=%02h cpu_reset=%0b busy=%0b done=%0b",
                     tag, n, rom_a_addr, ram_a_we, ram_a_addr, ram_a_wdata, cpu_a_reset, busy_a, done_a);
            if (n == reload_after_row) reload_a = 1'b1;
        end
    endtask

    task automatic reload_from_run(input string tag);
        @(negedge clk);
        reload_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reload_a = 1'b0;
        chk({tag, ".cpu_reset"}, 0, 32'(cpu_a_reset), 32'd1);
        chk({tag, ".done"}, 0, 32'(done_a), 32'd0);
        chk({tag, ".busy"}, 0, 32'(busy_a), 32'd1);
        $display("%s reload edge: cpu_reset=%0b busy=%0b done=%0b", tag, cpu_a_reset, busy_a, done_a);
    endtask

    initial begin
        int nwr, bad, last_addr, last_data, done_cyc, we_after;

        for (int n = 1; n <= 11; n++)
            tbl[n] = '{chk_rom: 1'b0, rom_addr: 8'd0, we: 1'b0, waddr: 8'd0, wdata: 8'd0,
                       cpu_reset: 1'b1, busy: 1'b1, done: 1'b0};
        for (int n = 1; n <= 7; n++) tbl[n].chk_rom = 1'b1;
        tbl[5].rom_addr = 8'd1;
        tbl[6].rom_addr = 8'd2;
        tbl[7].rom_addr = 8'd3;
        for (int n = 6; n <= 9; n++) begin
            tbl[n].we    = 1'b1;
            tbl[n].waddr = 8'(n - 6);
            tbl[n].wdata = 8'hA0 + 8'(n - 6);
        end
        for (int n = 10; n <= 11; n++) begin
            tbl[n].cpu_reset = 1'b0;
            tbl[n].busy      = 1'b0;
            tbl[n].done      = 1'b1;
        end

        // Reset held for three clocks
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.cpu_reset", 0, 32'(cpu_a_reset), 32'd1);
        chk("rst.busy", 0, 32'(busy_a), 32'd1);
        chk("rst.done", 0, 32'(done_a), 32'd0);
        chk("rst.ram_we", 0, 32'(ram_a_we), 32'd0);
        chk("rst.rom_addr", 0, 32'(rom_a_addr), 32'd0);
        $display("reset: cpu_reset=%0b busy=%0b done=%0b we=%0b", cpu_a_reset, busy_a, done_a, ram_a_we);
        reset_a = 1'b1;
        run_table("boot", 0);

        reload_from_run("reload_run");
        run_table("reload_run", 0);

        reload_from_run("reload_copy");
        run_table("reload_copy", 7);

        // Asynchronous reset mid-cycle while the write to address 2 is on the bus
        reload_from_run("midrst");
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("midrst.pre_we", 8, 32'(ram_a_we), 32'd1);
        chk("midrst.pre_addr", 8, 32'(ram_a_addr), 32'd2);
        #2 reset_a = 1'b0;
        #1;
        chk("midrst.we_drop", 8, 32'(ram_a_we), 32'd0);
        chk("midrst.cpu_reset", 8, 32'(cpu_a_reset), 32'd1);
        $display("midrst: async reset applied, we=%0b cpu_reset=%0b", ram_a_we, cpu_a_reset);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst.hold_cpu_reset", 9, 32'(cpu_a_reset), 32'd1);
        reset_a = 1'b1;
        run_table("midrst", 0);

        // Full 256-word wrap
        @(negedge clk);
        reset_b  = 1'b1;
        nwr = 0; bad = 0; last_addr = -1; last_data = -1; done_cyc = 0; we_after = 0;
        for (int cyc = 1; cyc <= 270; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (ram_b_we) begin
                if (ram_b_addr != 8'(nwr) || ram_b_wdata != (8'(nwr) ^ 8'h5A)) bad++;
                last_addr = int'(ram_b_addr);
                last_data = int'(ram_b_wdata);
                nwr++;
                if (done_b) we_after++;
            end
            if (done_b && done_cyc == 0) done_cyc = cyc;
            if (done_cyc != 0 && ram_b_we) we_after++;
        end
        chk("wrap.writes", 0, 32'(nwr), 32'd256);
        chk("wrap.order", 0, 32'(bad), 32'd0);
        chk("wrap.last_addr", 0, 32'(last_addr), 32'd255);
        chk("wrap.last_data", 0, 32'(last_data), 32'hA5);
        chk("wrap.done_cycle", 0, 32'(done_cyc), 32'd262);
        chk("wrap.we_after_done", 0, 32'(we_after), 32'd0);
        chk("wrap.cpu_reset", 0, 32'(cpu_b_reset), 32'd0);
        $display("wrap: writes=%0d last=(%0d,%02h) done_cycle=%0d", nwr, last_addr, last_data, done_cyc);

        // LENGTH=1, SETTLE_CYCLES=1
        @(negedge clk);
        reset_c = 1'b1;
        nwr = 0; last_addr = -1; last_data = -1; done_cyc = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            if (ram_c_we) begin
                last_addr = int'(ram_c_addr);
                last_data = int'(ram_c_wdata);
                nwr++;
            end
            if (done_c && done_cyc == 0) done_cyc = cyc;
        end
        chk("len1.writes", 0, 32'(nwr), 32'd1);
        chk("len1.addr", 0, 32'(last_addr), 32'd0);
        chk("len1.data", 0, 32'(last_data), 32'h3C);
        chk("len1.done_cycle", 0, 32'(done_cyc), 32'd4);
        $display("len1: writes=%0d write=(%0d,%02h) done_cycle=%0d", nwr, last_addr, last_data, done_cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits directly downstream of the startup reset generator in the 8-bit machine.
- After reset is released, copies a fixed-length program image from the on-chip ROM into the CPU's RAM.
- Holds the CPU in reset during the copy and releases it only once the image is fully written.
- Can be re-triggered by a reload pulse, for example from a debug button.

Parameters:
- ADDR_WIDTH, 8, width of the ROM and RAM address buses.
- DATA_WIDTH, 8, width of the ROM and RAM data buses.
- LENGTH, 256, number of words copied; legal range 1..2**ADDR_WIDTH.
- SETTLE_CYCLES, 4, idle cycles after reset release before the first ROM read; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset); driven from the startup block output through an inverter at top level.
- reload  in  1  single-cycle pulse; restarts the copy when in RUN.
- rom_addr  out  ADDR_WIDTH  ROM read address; the ROM registers the read, so data arrives one cycle later.
- rom_data  in  DATA_WIDTH  ROM read data.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_WIDTH  RAM write address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- cpu_reset  out  1  active-high reset to the CPU.
- busy  out  1  high while in SETTLE, COPY or FLUSH.
- done  out  1  high in RUN.

Behaviour:
- States: SETTLE, COPY, FLUSH, RUN. Encoding lives in the package.
- While reset=0 (asynchronous):
  - state=SETTLE, settle counter=0, read pointer=0.
  - rom_addr=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - cpu_reset=1, busy=1, done=0.
- SETTLE:
  - Counter increments every clock.
  - When counter==SETTLE_CYCLES-1, go to COPY and drive rom_addr=0.
  - First ROM read is issued SETTLE_CYCLES edges after reset deasserts.
- COPY:
  - Each cycle issues a read at the read pointer and increments it.
  - Pipeline: the read issued in cycle k returns in cycle k+1. That same cycle registers ram_we=1, ram_addr=k, ram_wdata=rom_data, which are visible to the RAM in cycle k+2.
  - After issuing address LENGTH-1, go to FLUSH.
- FLUSH:
  - Waits for the last write, to address LENGTH-1, to be driven for one cycle.
  - Then ram_we=0 and go to RUN.
- RUN:
  - cpu_reset=0, busy=0, done=1, ram_we=0.
  - cpu_reset deasserts on the cycle after the final ram_we cycle. No CPU cycle overlaps a loader write.
- Throughput and latency:
  - Exactly one write per cycle with no gaps.
  - Exactly LENGTH writes per copy, at addresses 0..LENGTH-1 in ascending order.
  - Total cycles from reset release to done=1 = SETTLE_CYCLES + LENGTH + 2.
- Wrap-around with LENGTH=2**ADDR_WIDTH:
  - Termination uses a separate ADDR_WIDTH+1 bit count, not pointer overflow.
  - No write to address 0 after the last write.
- LENGTH=1: COPY lasts one cycle, then FLUSH, then RUN.
- reload:
  - Honoured only in RUN. It returns the block to SETTLE with cpu_reset=1 and done=0 on the next edge, and the counter and pointer are cleared.
  - Ignored in SETTLE, COPY and FLUSH; no restart and no corruption.
- Reset during COPY or FLUSH: ram_we drops immediately (asynchronously). Any partial image is abandoned and the copy restarts from address 0.
- Registered outputs only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package boot_pkg holds:
  - the state enum (SETTLE, COPY, FLUSH, RUN);
  - default parameter constants;
  - a localparam for the count width (ADDR_WIDTH+1).
- One natural sub-module, boot_settle_counter: a free-running settle counter with a terminal-count flag, async active-low clear and a synchronous restart. It is also reusable by other startup sequencing.
- Copy FSM and write pipeline stay in boot_loader.

Test Plan:
- Reset and ROM setup: LENGTH=4, SETTLE_CYCLES=4, ROM preloaded with {0xA0,0xA1,0xA2,0xA3}; hold reset=0 for 3 clocks.
  - During reset, required: cpu_reset=1, busy=1, done=0, ram_we=0.
  - After release, required: rom_addr steps 0,1,2,3 starting at edge 4.
  - Required writes: (0,0xA0), (1,0xA1), (2,0xA2), (3,0xA3) on 4 consecutive cycles.
  - Required: done=1 and cpu_reset=0 exactly 10 cycles after release.
- Full wrap: LENGTH=256, ROM[i]=i^0x5A.
  - Required: 256 writes, the last being (255, 0xA5).
  - Required: no further ram_we, and done=1 at cycle 262.
- Reload from RUN: after done=1, pulse reload for 1 cycle.
  - Required on the next edge: cpu_reset=1, done=0, busy=1.
  - Required: the copy repeats identically and done returns after 10 cycles.
- Reload during COPY: pulse reload while ram_addr=1 (LENGTH=4).
  - Required: no restart, 4 writes total, done at cycle 10.
- Mid-copy reset: assert reset=0 asynchronously mid-cycle while ram_addr=2.
  - Required: ram_we=0 before the next clock edge, and cpu_reset stays 1.
  - After release, required: writes restart at address 0 and done=1 at 10 cycles.
- LENGTH=1, SETTLE_CYCLES=1:
  - Required: a single write (0, ROM[0]) and done=1 at cycle 4 after release.
